bus_arbiter_16: RTL and testbench

BUS_ARBITER_16 -- requirements
Module: bus_arbiter_16

---
 rtl/bus_arbiter_16_pkg.sv | 20 ++
 rtl/bus_arbiter_16_if.sv | 14 +
 rtl/bus_arbiter_16_rr_pick.sv | 30 +++
 rtl/bus_arbiter_16.sv | 96 +++++++++
 tb/tb_bus_arbiter_16.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_16_pkg.sv
// rtl/bus_arbiter_16_pkg.sv - shared sizes, state encoding and helpers for bus_arbiter_16
package bus_arbiter_16_pkg;

   localparam int NR_REQ = 16;
   localparam int SEL_W  = 4;
   localparam int HOLD_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   function automatic logic [NR_REQ-1:0] sel2mask(input logic [SEL_W-1:0] sel);
      logic [NR_REQ-1:0] m;
      m      = '0;
      m[sel] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/bus_arbiter_16_if.sv
// rtl/bus_arbiter_16_if.sv - request/grant bundle between requesters and bus_arbiter_16
interface bus_arbiter_16_if;
   import bus_arbiter_16_pkg::*;

   logic [NR_REQ-1:0] Req;
   logic [NR_REQ-1:0] Grant;
   logic [SEL_W-1:0]  Sel;
   logic              Enable;
   logic [HOLD_W-1:0] HoldCnt;

   modport master (output Req, input Grant, input Sel, input Enable, input HoldCnt);
   modport slave  (input Req, output Grant, output Sel, output Enable, output HoldCnt);

endinterface

// File: rtl/bus_arbiter_16_rr_pick.sv
// rtl/bus_arbiter_16_rr_pick.sv - rotating-priority search: first eligible request at or above Base
module rr_pick
   import bus_arbiter_16_pkg::*;
(
   input  logic [NR_REQ-1:0] Req,
   input  logic [SEL_W-1:0]  Base,
   input  logic [NR_REQ-1:0] Exclude,
   output logic [SEL_W-1:0]  Idx,
   output logic              Found
);

   logic [NR_REQ-1:0] cand;
   logic [SEL_W-1:0]  probe;

   always_comb begin
      cand  = Req & ~Exclude;
      Idx   = '0;
      Found = 1'b0;
      probe = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         // SEL_W-bit addition wraps 15 -> 0 for free
         probe = Base + SEL_W'(i);
         if (!Found && cand[probe]) begin
            Idx   = probe;
            Found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_16.sv
// rtl/bus_arbiter_16.sv - 16-way round-robin bus arbiter with bounded hold time
module bus_arbiter_16
   import bus_arbiter_16_pkg::*;
#(
   parameter int unsigned MaxHold = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   bus_arbiter_16_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MaxHold - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic [NR_REQ-1:0] holder_mask;
   logic [NR_REQ-1:0] excl;
   logic [SEL_W-1:0]  base;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_found;
   logic              granting;
   logic              at_limit;
   logic              others;
   logic              release_now;

   assign granting    = (state_q == ST_GRANT);
   assign holder_mask = sel2mask(sel_q);
   assign base        = last_q + SEL_W'(1);
   assign at_limit    = (hold_q == HOLD_LAST);
   assign others      = |(bus.Req & ~holder_mask);
   assign release_now = granting && (!bus.Req[sel_q] || (at_limit && others));
   // The holder never re-wins its own release, which matters on timeout
   assign excl        = granting ? holder_mask : '0;

   rr_pick u_pick (
      .Req     (bus.Req),
      .Base    (base),
      .Exclude (excl),
      .Idx     (pick_idx),
      .Found   (pick_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         last_q  <= '1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_GRANT;
               sel_d   = pick_idx;
               last_d  = pick_idx;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               hold_d = '0;
               if (pick_found) begin
                  sel_d  = pick_idx;
                  last_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               hold_d = at_limit ? '0 : hold_q + HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.Grant   = granting ? holder_mask : '0;
   assign bus.Enable  = granting;
   assign bus.Sel     = sel_q;
   assign bus.HoldCnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter_16.sv
// tb/tb_bus_arbiter_16.sv - scoreboard bench for bus_arbiter_16 against a round-robin reference model
module tb_bus_arbiter_16;

   localparam int MH    = 8;
   localparam int BOUND = 15 * MH + 1;

   typedef struct {
      logic [15:0] grant;
      logic [3:0]  sel;
      logic        en;
      logic [7:0]  hc;
   } exp_t;

   logic clk;
   logic rst_n;
   bus_arbiter_16_if bif();

   bus_arbiter_16 #(.MaxHold(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   int   wait_c[16];

   // reference model: who holds the bus, for how long, and who won last
   int m_last;
   int m_holder;
   int m_sel;
   int m_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int rr_first(input logic [15:0] r, input int base);
      for (int i = 0; i < 16; i++) begin
         if (r[(base + i) % 16]) return (base + i) % 16;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_last   = 15;
      m_holder = -1;
      m_sel    = 0;
      m_cnt    = 0;
   endfunction

   function automatic void model_step(input logic [15:0] r);
      logic [15:0] rest;
      int          w;
      if (m_holder < 0) begin
         w = rr_first(r, (m_last + 1) % 16);
         if (w >= 0) begin
            m_holder = w; m_last = w; m_sel = w; m_cnt = 0;
         end
      end else begin
         rest = r;
         rest[m_holder] = 1'b0;
         if (!r[m_holder] || (m_cnt == MH - 1 && rest != 0)) begin
            w = rr_first(rest, (m_last + 1) % 16);
            m_cnt = 0;
            m_holder = w;
            if (w >= 0) begin
               m_last = w; m_sel = w;
            end
         end else begin
            m_cnt = (m_cnt == MH - 1) ? 0 : m_cnt + 1;
         end
      end
   endfunction

   task automatic drive(input logic [15:0] r);
      exp_t e;
      @(negedge clk);
      bif.Req = r;
      model_step(r);
      e.grant = (m_holder >= 0) ? (16'h1 << m_holder) : 16'h0;
      e.sel   = 4'(m_sel);
      e.en    = (m_holder >= 0);
      e.hc    = 8'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // monitor: pops one expectation per edge and checks structural invariants
   initial begin
      exp_t e;
      for (int i = 0; i < 16; i++) wait_c[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", bif.Grant, e.grant);
            chk("sel", bif.Sel, e.sel);
            chk("enable", bif.Enable, e.en);
            chk("holdcnt", bif.HoldCnt, e.hc);
         end
         chk("grant_onehot0", $onehot0(bif.Grant), 1);
         if (bif.Enable) chk("sel_matches_grant", bif.Grant, 16'h1 << bif.Sel);
         else            chk("idle_grant_zero", bif.Grant, 16'h0);
         for (int i = 0; i < 16; i++) begin
            if (!rst_n || !bif.Req[i]) begin
               wait_c[i] = 0;
            end else if (bif.Grant[i]) begin
               if (wait_c[i] > 0) chk("wait_within_bound", (wait_c[i] <= BOUND), 1);
               wait_c[i] = 0;
            end else begin
               wait_c[i]++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] r;
      rst_n   = 1'b0;
      bif.Req = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_grant", bif.Grant, 16'h0);
      chk("reset_enable", bif.Enable, 1'b0);
      chk("reset_sel", bif.Sel, 4'h0);
      chk("reset_holdcnt", bif.HoldCnt, 8'h0);
      rst_n = 1'b1;

      drive(16'h0000);
      drive(16'h0001);
      settle();
      chk("first_grant", bif.Grant, 16'h0001);
      chk("first_enable", bif.Enable, 1'b1);
      chk("first_holdcnt", bif.HoldCnt, 8'h0);
      drive(16'h0000);

      drive(16'h0008);
      drive(16'h000A);
      drive(16'h0002);
      settle();
      chk("wrap_grant", bif.Grant, 16'h0002);
      chk("wrap_sel", bif.Sel, 4'h1);
      drive(16'h0000);

      repeat (16 * MH + MH) drive(16'hFFFF);
      drive(16'h0000);

      repeat (300) drive(16'h0020);
      settle();
      chk("solo_grant", bif.Grant, 16'h0020);
      drive(16'h0000);

      repeat (3) drive(16'h0200);
      settle();
      chk("pre_reset_grant", bif.Grant, 16'h0200);
      @(negedge clk);
      #2;
      rst_n   = 1'b0;
      bif.Req = '0;
      #1;
      chk("async_reset_grant", bif.Grant, 16'h0);
      chk("async_reset_enable", bif.Enable, 1'b0);
      chk("async_reset_sel", bif.Sel, 4'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(16'h0201);
      settle();
      chk("post_reset_grant", bif.Grant, 16'h0001);
      chk("post_reset_sel", bif.Sel, 4'h0);

      r = 16'h0201;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 16; i++) begin
            if (r[i] && i == m_holder) begin
               if ($urandom_range(0, 3) == 0) r[i] = 1'b0;
            end else if (!r[i]) begin
               if ($urandom_range(0, 7) == 0) r[i] = 1'b1;
            end
         end
         drive(r);
      end
      drive(16'h0000);
      settle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
